// File: rtl/psum_accum_pkg.sv
// rtl/psum_accum_pkg.sv - shared types, defaults and helpers for the psum drain stage
package psum_accum_pkg;

  // Default geometry of the drain stage
  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 5;

  // Value substituted for a negative lane when ReLU is enabled
  localparam logic [BW-1:0] RELU_ZERO = '0;

  // Drain FSM states: one FIFO word is consumed per WAIT->GAP1->GAP2 round trip
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    GAP1 = 3'd2,
    GAP2 = 3'd3,
    DONE = 3'd4
  } state_t;

  // Least significant bit of a lane inside a packed col*bw word
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/psum_lane_add.sv
// rtl/psum_lane_add.sv - one-lane wrapping accumulate with pass-0 bypass and ReLU
module psum_lane_add
  import psum_accum_pkg::*;
#(
  parameter int bw = BW
) (
  input  logic [bw-1:0] in_lane,
  input  logic [bw-1:0] acc_lane,
  input  logic          first_pass,
  input  logic          relu_en,
  output logic [bw-1:0] sum,
  output logic [bw-1:0] result
);

  // First pass overwrites stale accumulator contents; later passes add modulo 2^bw
  always_comb begin
    sum    = first_pass ? in_lane : (in_lane + acc_lane);
    result = (relu_en && sum[bw-1]) ? bw'(RELU_ZERO) : sum;
  end

endmodule

// File: rtl/psum_accum.sv
// rtl/psum_accum.sv - multi-pass psum accumulator draining the MAC output FIFO
module psum_accum
  import psum_accum_pkg::*;
#(
  parameter int col   = COL,
  parameter int bw    = BW,
  parameter int depth = DEPTH,
  parameter int aw    = AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [aw-1:0]     num_pos,
  input  logic [3:0]        num_pass,
  input  logic              relu_en,
  input  logic              ofifo_valid,
  input  logic [col*bw-1:0] ofifo_out,
  output logic              ofifo_rd,
  output logic              out_valid,
  output logic [aw-2:0]     out_addr,
  output logic [col*bw-1:0] out_data,
  output logic              busy,
  output logic              done
);

  state_t state, state_n;

  logic [aw-1:0]     pos_cnt, pos_cnt_n;
  logic [3:0]        pass_cnt, pass_cnt_n;
  logic [aw-1:0]     num_pos_r, num_pos_n;
  logic [3:0]        num_pass_r, num_pass_n;
  logic              relu_r, relu_n;

  logic              ofifo_rd_n, out_valid_n, busy_n, done_n;
  logic [aw-2:0]     out_addr_n;
  logic [col*bw-1:0] out_data_n;

  logic [col*bw-1:0] acc [depth];
  logic [col*bw-1:0] acc_rd;
  logic [col*bw-1:0] sum_word;
  logic [col*bw-1:0] result_word;
  logic              acc_we;
  logic              first_pass;
  logic              final_pass;
  logic              last_pos;

  assign acc_rd     = acc[pos_cnt[aw-2:0]];
  assign first_pass = (pass_cnt == 4'd0);
  assign final_pass = (pass_cnt == (num_pass_r - 4'd1));
  assign last_pos   = (pos_cnt == (num_pos_r - aw'(1)));

  for (genvar i = 0; i < col; i++) begin : g_lane
    localparam int LSB = lane_lsb(i, bw);
    psum_lane_add #(.bw(bw)) u_lane (
      .in_lane   (ofifo_out[LSB +: bw]),
      .acc_lane  (acc_rd[LSB +: bw]),
      .first_pass(first_pass),
      .relu_en   (relu_r),
      .sum       (sum_word[LSB +: bw]),
      .result    (result_word[LSB +: bw])
    );
  end

  // State, job parameters, counters and every output are registered here
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pos_cnt    <= '0;
      pass_cnt   <= '0;
      num_pos_r  <= '0;
      num_pass_r <= '0;
      relu_r     <= 1'b0;
      ofifo_rd   <= 1'b0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      pos_cnt    <= pos_cnt_n;
      pass_cnt   <= pass_cnt_n;
      num_pos_r  <= num_pos_n;
      num_pass_r <= num_pass_n;
      relu_r     <= relu_n;
      ofifo_rd   <= ofifo_rd_n;
      out_valid  <= out_valid_n;
      out_addr   <= out_addr_n;
      out_data   <= out_data_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  // Accumulator write; contents need no reset since pass 0 overwrites them
  always_ff @(posedge clk) begin
    if (acc_we) begin
      acc[pos_cnt[aw-2:0]] <= sum_word;
    end
  end

  // Next-state and next-output logic for the drain FSM
  always_comb begin
    state_n     = state;
    pos_cnt_n   = pos_cnt;
    pass_cnt_n  = pass_cnt;
    num_pos_n   = num_pos_r;
    num_pass_n  = num_pass_r;
    relu_n      = relu_r;
    ofifo_rd_n  = 1'b0;
    out_valid_n = 1'b0;
    out_addr_n  = out_addr;
    out_data_n  = out_data;
    done_n      = 1'b0;
    acc_we      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          num_pos_n  = num_pos;
          num_pass_n = (num_pass == 4'd0) ? 4'd1 : num_pass;
          relu_n     = relu_en;
          pos_cnt_n  = '0;
          pass_cnt_n = '0;
          if (num_pos == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (ofifo_valid) begin
          acc_we     = 1'b1;
          ofifo_rd_n = 1'b1;
          if (final_pass) begin
            out_valid_n = 1'b1;
            out_addr_n  = pos_cnt[aw-2:0];
            out_data_n  = result_word;
          end
          state_n = GAP1;
        end
      end
      GAP1: begin
        // Head stays stale for one more edge while the FIFO registers the pop
        state_n = GAP2;
      end
      GAP2: begin
        if (last_pos) begin
          pos_cnt_n = '0;
          if (final_pass) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            pass_cnt_n = pass_cnt + 4'd1;
            state_n    = WAIT;
          end
        end else begin
          pos_cnt_n = pos_cnt + aw'(1);
          state_n   = WAIT;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule
